// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS front end: word type, halt encoding,
// fetch FSM states and the IF/ID pipeline record.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and the cache.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register: flush beats load, otherwise the contents hold.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);
  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush)
      ifid_d = '0;
    else if (load)
      ifid_d = d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      ifid_q <= '0;
    else
      ifid_q <= ifid_d;
  end

  assign q = ifid_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, RUN/HALTED fetch FSM and IF/ID register.
// Optional FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  fetch_stage_if.master imem,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  output word_t ifid_instr,
  output word_t ifid_npc,
  output logic  ifid_valid,
  output logic  fetch_halted
`ifdef FETCH_PERF_EN
  ,
  output word_t fetch_count,
  output word_t bubble_count
`endif
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pc_plus4;
  word_t        redirect_tgt;
  logic         running;
  logic         halt_word;
  logic         do_load;
  logic         do_flush;
  ifid_t        ifid_new;
  ifid_t        ifid_cur;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'h3;
  assign running      = (state_q == RUN);
  assign halt_word    = (imem.imemload == HALT_INSTR);

  // Redirect wins over everything; a stalled cycle neither loads nor bubbles.
  assign do_load  = !redirect && !stall && running && imem.ihit;
  assign do_flush = redirect || (!stall && running && !imem.ihit);

  assign ifid_new = '{instr: imem.imemload, npc: pc_plus4, valid: 1'b1};

  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = redirect_tgt;
    else if (do_load && !halt_word)
      pc_d = pc_plus4;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q    <= PC_RESET;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = RUN;
    else if (do_load && halt_word)
      state_d = HALTED;
  end

  always_comb begin
    imem.imemREN  = (state_q == RUN);
    imem.imemaddr = pc_q;
    fetch_halted  = (state_q == HALTED);
  end

  ifid_latch u_ifid (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (do_load),
    .flush (do_flush),
    .d     (ifid_new),
    .q     (ifid_cur)
  );

  assign ifid_instr = ifid_cur.instr;
  assign ifid_npc   = ifid_cur.npc;
  assign ifid_valid = ifid_cur.valid;

`ifdef FETCH_PERF_EN
  word_t fetch_count_q, fetch_count_d;
  word_t bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, do_load};
    bubble_count_d = bubble_count_q + {31'd0, do_flush};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core. It owns the PC, issues instruction-memory reads through the datapath/cache interface signals, and latches the fetched word and PC+4 for the decode stage. The decode stage's control decoder consumes ifid_instr directly. An all-zero word is a bubble and decodes to no control activity.
- Honours hazard stalls, branch/jump redirects and halt.

Parameters:
PC_RESET, 32'h00000000, PC value loaded on reset.

Ports:
CLK  in  1  core clock; single clock domain.
nRST  in  1  asynchronous, active-low reset.
ihit  in  1  instruction-memory hit; imemload valid this cycle.
imemload  in  32  instruction word from memory.
imemREN  out  1  instruction read enable.
imemaddr  out  32  fetch address (current PC).
stall  in  1  hazard-unit hold of PC and IF/ID.
redirect  in  1  taken branch/jump/JR resolved downstream.
redirect_pc  in  32  target address for redirect.
ifid_instr  out  32  latched instruction; 0 = bubble.
ifid_npc  out  32  latched PC+4 of ifid_instr.
ifid_valid  out  1  ifid_instr is a real instruction.
fetch_halted  out  1  fetch FSM is in HALTED.

Behaviour:
Reset (async, nRST low):
- pc = PC_RESET; ifid_instr = 0; ifid_npc = 0; ifid_valid = 0.
- State = RUN; fetch_halted = 0; perf counters = 0.

Outputs:
- imemaddr = pc, always.
- imemREN = 1 in RUN; 0 in HALTED.
- fetch_halted = 1 iff state == HALTED.

Per rising edge, priority order (the first matching rule applies):
1. redirect=1, any state, regardless of stall or ihit:
   - pc <= {redirect_pc[31:2], 2'b00}.
   - ifid_instr <= 0; ifid_valid <= 0; ifid_npc <= 0.
   - State <= RUN.
   - A halt word fetched in the same cycle is discarded.
2. stall=1: pc, IF/ID and state all hold. imemREN stays asserted in RUN.
3. RUN, ihit=1:
   - ifid_instr <= imemload; ifid_npc <= pc+4; ifid_valid <= 1; pc <= pc+4.
   - If imemload == HALT_INSTR (32'hFFFFFFFF), state <= HALTED and pc holds (does not advance).
4. RUN, ihit=0: insert bubble (ifid_instr <= 0, ifid_valid <= 0, ifid_npc <= 0); pc holds.
5. HALTED with no redirect: IF/ID holds the halt word; pc holds; no fetch issued.

Arithmetic and boundary rules:
- pc+4 is 32-bit modulo: 32'hFFFFFFFC wraps to 0.
- Fetch latency: one cycle from ihit to IF/ID update; back-to-back hits give one instruction per cycle.
- A redirect while HALTED squashes the wrong-path halt and resumes fetching.

Optional Feature:
Macro: FETCH_PERF_EN.
Defined:
- Adds output ports fetch_count[31:0] and bubble_count[31:0].
- fetch_count increments on every rule-3 load.
- bubble_count increments on every rule-1 or rule-4 cycle.
- Both are cleared by reset and wrap at 2^32.
Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
cpu_types_pkg contains:
- word_t (32-bit).
- HALT_INSTR constant.
- fetch_state_t enum {RUN, HALTED}.
- ifid_t struct {instr, npc, valid}.
One sub-module, ifid_latch: the IF/ID register with load, flush and hold controls plus async nRST. The PC and FSM stay in fetch_stage.

Test Plan:
- Reset release, ihit=1 constantly, memory returning 0x24010001, 0x24020002 → imemaddr 0, 4, 8; ifid_npc 4 then 8; ifid_valid=1 from the first edge.
- ihit=0 for 3 cycles at pc=0x10 → ifid_instr=0 and ifid_valid=0 for 3 cycles; imemaddr stays 0x10; pc advances only on the next hit.
- stall=1 for 2 cycles with ihit=1 at pc=0x20 → IF/ID and pc unchanged; then stall drops → instruction at 0x20 latched, pc=0x24.
- redirect=1, redirect_pc=0x103, asserted together with stall=1 and ihit=1 → pc=0x100 next cycle; IF/ID flushed to 0.
- Fetch of 0xFFFFFFFF at pc=0x40 → HALTED; imemREN=0; ifid_instr=0xFFFFFFFF held. A later redirect to 0x80 → RUN, imemaddr=0x80, IF/ID flushed.
- pc=0xFFFFFFFC with a hit → next imemaddr=0. With FETCH_PERF_EN: after 5 hits and 2 misses, fetch_count=5 and bubble_count=2.
